// File: rtl/display_decode.sv
// Loopback monitor for a multiplexed seven-segment bus: synchronizes AN/CA, samples each
// stable digit phase once, and republishes the ones/tens pair with error and stall flags.
module display_decode #(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] AN,
    input  logic       CA,
    output logic [3:0] NUM_1S,
    output logic [2:0] NUM_10S,
    output logic       VALID,
    output logic       ERR,
    output logic       STALL
);

    localparam int SW = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] STC_MAX = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_PRE = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        WAIT_CHG = 2'd0,
        SETTLE   = 2'd1,
        HOLD     = 2'd2
    } state_t;

    // Returns {legal, digit}; anything outside the ten digit glyphs is illegal.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   seg_decode = {1'b1, 4'd0};
            7'h06:   seg_decode = {1'b1, 4'd1};
            7'h5B:   seg_decode = {1'b1, 4'd2};
            7'h4F:   seg_decode = {1'b1, 4'd3};
            7'h66:   seg_decode = {1'b1, 4'd4};
            7'h6D:   seg_decode = {1'b1, 4'd5};
            7'h7D:   seg_decode = {1'b1, 4'd6};
            7'h07:   seg_decode = {1'b1, 4'd7};
            7'h7F:   seg_decode = {1'b1, 4'd8};
            7'h6F:   seg_decode = {1'b1, 4'd9};
            default: seg_decode = {1'b0, 4'd0};
        endcase
    endfunction

    logic [6:0]    an_m_q, an_s_q, an_p_q;
    logic          ca_m_q, ca_s_q, ca_p_q;
    logic [SW-1:0] stc_q, stc_d;
    logic          smp_done_q, smp_done_d;
    state_t        state_q, state_d;
    logic [3:0]    sh1_q, sh1_d;
    logic [2:0]    sh10_q, sh10_d;
    logic          f1_q, f1_d, f10_q, f10_d;
    logic [3:0]    num1_q, num1_d;
    logic [2:0]    num10_q, num10_d;
    logic          valid_q, valid_d, err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          stall_q, stall_d;

    logic          chg_s, ca_edge_s, sample_s, stall_hit_s, legal_s;
    logic [4:0]    dec_s;

    // Two-flop synchronizers plus the previous-value copy used for change detection.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            an_m_q <= 7'd0;
            an_s_q <= 7'd0;
            an_p_q <= 7'd0;
            ca_m_q <= 1'b0;
            ca_s_q <= 1'b0;
            ca_p_q <= 1'b0;
        end else begin
            an_m_q <= AN;
            an_s_q <= an_m_q;
            an_p_q <= an_s_q;
            ca_m_q <= CA;
            ca_s_q <= ca_m_q;
            ca_p_q <= ca_s_q;
        end
    end

    // Stability tracking, sampling, slot bookkeeping and stall detection.
    always_comb begin
        chg_s       = ({ca_s_q, an_s_q} != {ca_p_q, an_p_q});
        ca_edge_s   = (ca_s_q != ca_p_q);
        sample_s    = (state_q == SETTLE) && (stc_q == STC_MAX) && !smp_done_q && !chg_s;
        stall_hit_s = !ca_edge_s && (tmo_q == TMO_PRE);
        dec_s       = seg_decode(an_s_q);
        legal_s     = dec_s[4] && (!ca_s_q || (dec_s[3:0] <= 4'd5));

        stc_d      = stc_q;
        smp_done_d = smp_done_q;
        state_d    = state_q;
        sh1_d      = sh1_q;
        sh10_d     = sh10_q;
        f1_d       = f1_q && !stall_hit_s;
        f10_d      = f10_q && !stall_hit_s;
        num1_d     = num1_q;
        num10_d    = num10_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        tmo_d      = tmo_q;
        stall_d    = stall_q;

        if (chg_s) begin
            stc_d      = {SW{1'b0}};
            smp_done_d = 1'b0;
        end else if (stc_q != STC_MAX) begin
            stc_d = stc_q + 1'b1;
        end else begin
            stc_d = stc_q;
        end
        if (sample_s) begin
            smp_done_d = 1'b1;
        end else begin
            smp_done_d = smp_done_d;
        end

        case (state_q)
            WAIT_CHG: state_d = chg_s ? SETTLE : WAIT_CHG;
            SETTLE:   state_d = sample_s ? HOLD : SETTLE;
            HOLD:     state_d = chg_s ? SETTLE : HOLD;
            default:  state_d = SETTLE;
        endcase

        // A pair is published on the legal sample that completes it, including that sample.
        if (sample_s) begin
            if (!legal_s) begin
                err_d = 1'b1;
            end else if (!ca_s_q) begin
                sh1_d = dec_s[3:0];
                f1_d  = 1'b1;
                if (f10_d) begin
                    num1_d  = dec_s[3:0];
                    num10_d = sh10_q;
                    valid_d = 1'b1;
                    f1_d    = 1'b0;
                    f10_d   = 1'b0;
                end else begin
                    valid_d = 1'b0;
                end
            end else begin
                sh10_d = dec_s[2:0];
                f10_d  = 1'b1;
                if (f1_d) begin
                    num1_d  = sh1_q;
                    num10_d = dec_s[2:0];
                    valid_d = 1'b1;
                    f1_d    = 1'b0;
                    f10_d   = 1'b0;
                end else begin
                    valid_d = 1'b0;
                end
            end
        end else begin
            err_d = 1'b0;
        end

        // A CA edge takes priority over a coincident timeout.
        if (ca_edge_s) begin
            tmo_d   = {TW{1'b0}};
            stall_d = 1'b0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d   = tmo_q + 1'b1;
            stall_d = (tmo_q == TMO_PRE);
        end else begin
            tmo_d   = tmo_q;
            stall_d = 1'b1;
        end
    end

    // Decoder state and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stc_q      <= {SW{1'b0}};
            smp_done_q <= 1'b0;
            state_q    <= SETTLE;
            sh1_q      <= 4'd0;
            sh10_q     <= 3'd0;
            f1_q       <= 1'b0;
            f10_q      <= 1'b0;
            num1_q     <= 4'd0;
            num10_q    <= 3'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= {TW{1'b0}};
            stall_q    <= 1'b0;
        end else begin
            stc_q      <= stc_d;
            smp_done_q <= smp_done_d;
            state_q    <= state_d;
            sh1_q      <= sh1_d;
            sh10_q     <= sh10_d;
            f1_q       <= f1_d;
            f10_q      <= f10_d;
            num1_q     <= num1_d;
            num10_q    <= num10_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            stall_q    <= stall_d;
        end
    end

    assign NUM_1S  = num1_q;
    assign NUM_10S = num10_q;
    assign VALID   = valid_q;
    assign ERR     = err_q;
    assign STALL   = stall_q;

endmodule

// File: tb/tb_display_decode.sv
// Directed bench for display_decode with SETTLE_CYC = 4 and TIMEOUT_CYC = 50.
module tb_display_decode;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [6:0] AN  = 7'd0;
    logic       CA  = 1'b0;
    logic [3:0] NUM_1S;
    logic [2:0] NUM_10S;
    logic       VALID, ERR, STALL;

    int n_vec = 0;
    int n_miss = 0;
    int vcnt = 0;
    int ecnt = 0;
    int excl_viol = 0;
    int v_at, hi_at, lo_at;

    display_decode #(.SETTLE_CYC(4), .TIMEOUT_CYC(50)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .AN      (AN),
        .CA      (CA),
        .NUM_1S  (NUM_1S),
        .NUM_10S (NUM_10S),
        .VALID   (VALID),
        .ERR     (ERR),
        .STALL   (STALL)
    );

    always #4 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Drive one bus phase for ncyc edges, observing #1 after each edge.
    // v_at/hi_at/lo_at: first edge index with VALID, STALL high, STALL low (0 = never).
    task automatic phase(input logic ca, input logic [6:0] an, input int ncyc);
        CA = ca;
        AN = an;
        v_at = 0;
        hi_at = 0;
        lo_at = 0;
        for (int i = 1; i <= ncyc; i++) begin
            @(posedge CLK);
            #1;
            if (VALID) begin
                vcnt++;
                if (v_at == 0) v_at = i;
            end
            if (ERR) ecnt++;
            if (VALID && ERR) excl_viol++;
            if (STALL && hi_at == 0) hi_at = i;
            if (!STALL && lo_at == 0) lo_at = i;
        end
    endtask

    initial begin
        // Reset held with bus activity
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            CA = ~CA;
            AN = 7'(i * 13 + 5);
        end
        chk("rst_num1", int'(NUM_1S), 0);
        chk("rst_num10", int'(NUM_10S), 0);
        chk("rst_valid", int'(VALID), 0);
        chk("rst_err", int'(ERR), 0);
        chk("rst_stall", int'(STALL), 0);

        RST = 1'b1;
        phase(1'b0, 7'h06, 10);
        chk("half_pair_novalid", vcnt, 0);
        chk("half_pair_noerr", ecnt, 0);

        phase(1'b1, 7'h4F, 10);
        chk("basic_latency", v_at, 7);
        chk("basic_vcnt", vcnt, 1);
        chk("basic_num1", int'(NUM_1S), 1);
        chk("basic_num10", int'(NUM_10S), 3);
        chk("basic_nostall", hi_at, 0);

        // Blank ones pattern: ERR, slot not filled
        phase(1'b0, 7'h00, 10);
        chk("blank_err", ecnt, 1);
        chk("blank_novalid", vcnt, 1);
        phase(1'b1, 7'h5B, 10);
        chk("blank_no_f1", vcnt, 1);
        phase(1'b0, 7'h06, 10);
        chk("pair12_vcnt", vcnt, 2);
        chk("pair12_num1", int'(NUM_1S), 1);
        chk("pair12_num10", int'(NUM_10S), 2);

        // Tens digit 6 is out of range
        phase(1'b1, 7'h7D, 10);
        chk("tens6_err", ecnt, 2);
        chk("tens6_novalid", vcnt, 2);
        chk("tens6_num10", int'(NUM_10S), 2);
        phase(1'b0, 7'h4F, 10);
        chk("tens6_no_f10", vcnt, 2);

        // Mid-operation reset with a pending ones sample (3)
        RST = 1'b0;
        CA = 1'b1;
        AN = 7'h4F;
        #1;
        chk("midrst_num1", int'(NUM_1S), 0);
        chk("midrst_num10", int'(NUM_10S), 0);
        for (int i = 0; i < 3; i++) @(posedge CLK);
        #1;
        RST = 1'b1;
        phase(1'b1, 7'h4F, 10);
        chk("midrst_flags_cleared", vcnt, 2);
        phase(1'b0, 7'h06, 10);
        chk("midrst_pair_vcnt", vcnt, 3);
        chk("midrst_pair_lat", v_at, 7);
        chk("midrst_num1", int'(NUM_1S), 1);
        chk("midrst_num10", int'(NUM_10S), 3);

        // Glitch: short 06 phase cut off exactly at sample time, then 2-cycle 7F
        phase(1'b1, 7'h3F, 10);
        chk("glitch_tens_novalid", vcnt, 3);
        phase(1'b0, 7'h06, 4);
        phase(1'b0, 7'h7F, 2);
        phase(1'b0, 7'h06, 10);
        chk("glitch_vcnt", vcnt, 4);
        chk("glitch_lat", v_at, 7);
        chk("glitch_noerr", ecnt, 2);
        chk("glitch_num1", int'(NUM_1S), 1);
        chk("glitch_num10", int'(NUM_10S), 0);

        // Ones overwritten before tens arrives
        phase(1'b0, 7'h5B, 10);
        phase(1'b0, 7'h4F, 10);
        chk("ovw_novalid", vcnt, 4);
        phase(1'b1, 7'h66, 10);
        chk("ovw_vcnt", vcnt, 5);
        chk("ovw_num1", int'(NUM_1S), 3);
        chk("ovw_num10", int'(NUM_10S), 4);

        // Stall: CA frozen 60 cycles after a pending ones sample (6)
        phase(1'b0, 7'h7D, 60);
        chk("stall_rise_edge", hi_at, 53);
        chk("stall_level", int'(STALL), 1);
        chk("stall_novalid", vcnt, 5);
        phase(1'b1, 7'h3F, 10);
        chk("stall_fall_edge", lo_at, 3);
        chk("stall_flags_cleared", vcnt, 5);
        phase(1'b0, 7'h6F, 10);
        chk("resume_vcnt", vcnt, 6);
        chk("resume_lat", v_at, 7);
        chk("resume_num1", int'(NUM_1S), 9);
        chk("resume_num10", int'(NUM_10S), 0);
        chk("resume_err_total", ecnt, 2);

        chk("valid_err_exclusive", excl_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
